// File: rtl/stream_mux_rr.sv
// N-input, W-bit valid/ready stream multiplexer with a registered output stage.
// Grants come from a fixed select index or from a rotating round-robin search.
module stream_mux_rr #(
  parameter  int unsigned N    = 4,
  parameter  int unsigned W    = 8,
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic [SELW-1:0]   out_src,
  input  logic              out_ready
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_src_q,   out_src_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic            load;
  logic            fix_valid;
  logic            rr_valid;
  logic [SELW-1:0] rr_idx;
  logic            grant_valid;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    grant_data;
  logic            transfer;

  // Channel index base+off, wrapped into 0..N-1 (off is always < N).
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return SELW'(s);
  endfunction

  assign load = !out_valid_q || out_ready;

  // Fixed select: an out-of-range sel matches no channel and grants nothing.
  always_comb begin
    fix_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sel == SELW'(i)) fix_valid = in_valid[i];
    end
  end

  // Round-robin: first requester at or after ptr, wrapping past N-1.
  always_comb begin
    rr_valid = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!rr_valid && in_valid[wrap_add(ptr_q, k)]) begin
        rr_valid = 1'b1;
        rr_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  assign grant_valid = mode ? rr_valid : fix_valid;
  assign grant_idx   = mode ? rr_idx   : sel;

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        in_ready[i] = rst_n && load && grant_valid;
        grant_data  = in_data[i*W +: W];
      end
    end
  end

  assign transfer = |(in_ready & in_valid);

  // Output stage: load on transfer, drain when free with nothing granted, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load) out_valid_d = transfer;
    if (transfer) begin
      out_data_d = grant_data;
      out_src_d  = grant_idx;
      if (mode) begin
        ptr_d = (32'(grant_idx) == N - 1) ? '0 : SELW'(32'(grant_idx) + 32'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
